// File: rtl/sercmp_pkg.sv
// Shared types and helpers for the bit-serial magnitude comparator.
// Optional LSB-first operation is selected by the SERCMP_LSB_FIRST_EN macro in the top.
package sercmp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } sercmp_state_t;

   typedef struct packed {
      logic eq;
      logic lt;
      logic gt;
   } cmp_result_t;

   function automatic int cnt_width(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/sercmp_bit_counter.sv
// Counts accepted bit pairs of one operand transfer; flags the final bit as it is accepted.
import sercmp_pkg::*;

module sercmp_bit_counter #(
   parameter int N = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    inc,
   output logic [cnt_width(N)-1:0] count,
   output logic                    last
);

   localparam int CW = cnt_width(N);

   assign last = inc && (count == CW'(N - 1));

   // Wrapping to zero on the final bit keeps non-power-of-two N consistent.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clr || last) begin
         count <= '0;
      end else if (inc) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial unsigned magnitude comparator: two operands arrive one bit pair per cycle.
// Define SERCMP_LSB_FIRST_EN for LSB-first operand order (default is MSB first).
import sercmp_pkg::*;

module serial_mag_comparator #(
   parameter int N = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic bit_valid,
   input  logic a_bit,
   input  logic b_bit,
   output logic busy,
   output logic result_valid,
   output logic eq,
   output logic lt,
   output logic gt
);

   localparam int CW = cnt_width(N);

   sercmp_state_t state, state_n;
   logic          decided, decided_n;
   logic          lt_r, lt_n;
   logic          gt_r, gt_n;
   logic          load_res;
   cmp_result_t   res_q;

   logic          cnt_clr;
   logic          cnt_inc;
   logic          cnt_last;
   logic [CW-1:0] bit_count;
   logic          final_bit;

   // Start always wins over bit_valid, so a bit offered with start is never counted.
   assign cnt_clr   = start;
   assign cnt_inc   = (state == SHIFT) && bit_valid && !start;
   assign final_bit = cnt_last && (bit_count == CW'(N - 1));

   sercmp_bit_counter #(.N(N)) u_bit_counter (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .count (bit_count),
      .last  (cnt_last)
   );

   always_comb begin
      state_n   = state;
      decided_n = decided;
      lt_n      = lt_r;
      gt_n      = gt_r;
      load_res  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               decided_n = 1'b0;
               lt_n      = 1'b0;
               gt_n      = 1'b0;
               state_n   = SHIFT;
            end
         end
         SHIFT: begin
            if (start) begin
               decided_n = 1'b0;
               lt_n      = 1'b0;
               gt_n      = 1'b0;
            end else if (bit_valid) begin
`ifdef SERCMP_LSB_FIRST_EN
               // Later bits are more significant, so every difference overrides.
               if (a_bit != b_bit) begin
                  gt_n = a_bit;
                  lt_n = b_bit;
               end
`else
               if (!decided && (a_bit != b_bit)) begin
                  decided_n = 1'b1;
                  gt_n      = a_bit;
                  lt_n      = b_bit;
               end
`endif
               if (final_bit) begin
                  load_res = 1'b1;
                  state_n  = DONE;
               end
            end
         end
         DONE: begin
            if (start) begin
               decided_n = 1'b0;
               lt_n      = 1'b0;
               gt_n      = 1'b0;
               state_n   = SHIFT;
            end else begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         decided <= 1'b0;
         lt_r    <= 1'b0;
         gt_r    <= 1'b0;
         res_q   <= '0;
      end else begin
         state   <= state_n;
         decided <= decided_n;
         lt_r    <= lt_n;
         gt_r    <= gt_n;
         // Result register is loaded as DONE is entered so it is valid with the strobe.
         if (load_res) begin
            res_q.eq <= !(lt_n || gt_n);
            res_q.lt <= lt_n;
            res_q.gt <= gt_n;
         end
      end
   end

   assign busy         = (state == SHIFT);
   assign result_valid = (state == DONE);
   assign eq           = res_q.eq;
   assign lt           = res_q.lt;
   assign gt           = res_q.gt;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Self-checking bench for serial_mag_comparator; expected {eq,lt,gt} go through a queue.
// Operand order follows SERCMP_LSB_FIRST_EN when it is defined.
module tb_serial_mag_comparator;

   localparam int N = 16;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic bit_valid;
   logic a_bit;
   logic b_bit;
   logic busy;
   logic result_valid;
   logic eq;
   logic lt;
   logic gt;

   int total = 0;
   int bad   = 0;
   logic [2:0] exp_q[$];

   serial_mag_comparator #(.N(N)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .bit_valid    (bit_valid),
      .a_bit        (a_bit),
      .b_bit        (b_bit),
      .busy         (busy),
      .result_valid (result_valid),
      .eq           (eq),
      .lt           (lt),
      .gt           (gt)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] expect_of(input logic [N-1:0] a, input logic [N-1:0] b);
      return {a == b, a < b, a > b};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Start with random noise on the bit lines; those bits must be ignored.
   task automatic do_start();
      start     = 1'b1;
      bit_valid = 1'($urandom_range(0, 1));
      a_bit     = 1'($urandom_range(0, 1));
      b_bit     = 1'($urandom_range(0, 1));
      step();
      start     = 1'b0;
      bit_valid = 1'b0;
      total++;
      if (busy !== 1'b1 || result_valid !== 1'b0) begin
         bad++;
         $display("FAIL start_accept busy=%b result_valid=%b required busy=1 result_valid=0",
                  busy, result_valid);
      end
   endtask

   task automatic send_bits(input logic [N-1:0] a, input logic [N-1:0] b,
                            input int gap, input int nbits);
      logic [2:0] e;
      logic [2:0] got;
      for (int k = 0; k < nbits; k++) begin
         int idx;
`ifdef SERCMP_LSB_FIRST_EN
         idx = k;
`else
         idx = N - 1 - k;
`endif
         for (int g = 0; g < gap; g++) begin
            bit_valid = 1'b0;
            a_bit     = 1'($urandom_range(0, 1));
            b_bit     = 1'($urandom_range(0, 1));
            step();
         end
         bit_valid = 1'b1;
         a_bit     = a[idx];
         b_bit     = b[idx];
         step();
         bit_valid = 1'b0;
         total++;
         if (k < N - 1) begin
            if (result_valid !== 1'b0 || busy !== 1'b1) begin
               bad++;
               $display("FAIL early_strobe bit=%0d result_valid=%b busy=%b required 0/1",
                        k, result_valid, busy);
            end
         end else begin
            if (result_valid !== 1'b1 || busy !== 1'b0) begin
               bad++;
               $display("FAIL strobe_latency result_valid=%b busy=%b required 1/0",
                        result_valid, busy);
            end
            total++;
            got = {eq, lt, gt};
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL result_unexpected got eq/lt/gt=%b required no result", got);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin
                  bad++;
                  $display("FAIL result a=%h b=%h got eq/lt/gt=%b required %b", a, b, got, e);
               end
            end
         end
      end
   endtask

   task automatic check_idle_hold(input logic [2:0] e, input string name);
      step();
      total++;
      if (result_valid !== 1'b0 || {eq, lt, gt} !== e) begin
         bad++;
         $display("FAIL %s result_valid=%b eq/lt/gt=%b required 0 and %b",
                  name, result_valid, {eq, lt, gt}, e);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      bit_valid = 1'b0;
      a_bit = 1'b0;
      b_bit = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      step();
      total++;
      if ({busy, result_valid, eq, lt, gt} !== 5'b0) begin
         bad++;
         $display("FAIL reset_state busy/rv/eq/lt/gt=%b required 00000",
                  {busy, result_valid, eq, lt, gt});
      end
   endtask

   task automatic test_equal();
      exp_q.push_back(expect_of(16'hA5A5, 16'hA5A5));
      do_start();
      send_bits(16'hA5A5, 16'hA5A5, 0, N);
      check_idle_hold(3'b100, "equal_hold");
   endtask

   task automatic test_first_bit_decides();
      exp_q.push_back(expect_of(16'h8000, 16'h7FFF));
      do_start();
      send_bits(16'h8000, 16'h7FFF, 0, N);
      check_idle_hold(3'b001, "first_bit_hold");
   endtask

   task automatic test_gaps();
      exp_q.push_back(expect_of(16'h0001, 16'h0002));
      do_start();
      send_bits(16'h0001, 16'h0002, 1, N);
      check_idle_hold(3'b010, "gap_hold");
   endtask

   task automatic test_abort();
      do_start();
      send_bits(N'($urandom), N'($urandom), 0, 5);
      exp_q.push_back(expect_of(16'h1234, 16'h1235));
      do_start();
      send_bits(16'h1234, 16'h1235, 0, N);
      check_idle_hold(3'b010, "abort_hold");
   endtask

   task automatic test_reset_mid();
      do_start();
      send_bits(16'hFFFF, 16'h0000, 0, 8);
      rst       = 1'b1;
      start     = 1'b1;
      bit_valid = 1'b1;
      step();
      rst       = 1'b0;
      start     = 1'b0;
      bit_valid = 1'b0;
      total++;
      if ({busy, result_valid, eq, lt, gt} !== 5'b0) begin
         bad++;
         $display("FAIL reset_mid busy/rv/eq/lt/gt=%b required 00000",
                  {busy, result_valid, eq, lt, gt});
      end
      step();
      total++;
      if (busy !== 1'b0 || result_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_priority busy=%b result_valid=%b required 0/0", busy, result_valid);
      end
      exp_q.push_back(expect_of(16'h0000, 16'h0000));
      do_start();
      send_bits(16'h0000, 16'h0000, 0, N);
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [2:0]   e;
      exp_q.push_back(expect_of(16'h00FF, 16'h0F00));
      do_start();
      send_bits(16'h00FF, 16'h0F00, 0, N);
      e = 3'b010;
      for (int i = 0; i < 8; i++) begin
         a = N'($urandom);
         b = (i % 3 == 0) ? a : N'($urandom);
         if (i == 5) b = a ^ 16'h0001;
         e = expect_of(a, b);
         exp_q.push_back(e);
         do_start();
         send_bits(a, b, $urandom_range(0, 2), N);
      end
      check_idle_hold(e, "back_to_back_hold");
   endtask

`ifdef SERCMP_LSB_FIRST_EN
   task automatic test_lsb_first();
      exp_q.push_back(expect_of(16'h0003, 16'h0002));
      do_start();
      send_bits(16'h0003, 16'h0002, 0, N);
      exp_q.push_back(expect_of(16'h0100, 16'h00FF));
      do_start();
      send_bits(16'h0100, 16'h00FF, 0, N);
      check_idle_hold(3'b001, "lsb_first_hold");
   endtask
`endif

   initial begin
      test_reset();
      test_equal();
      test_first_bit_decides();
      test_gaps();
      test_abort();
      test_reset_mid();
      test_back_to_back();
`ifdef SERCMP_LSB_FIRST_EN
      test_lsb_first();
`endif
      repeat (3) step();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL leftover_results pending=%0d required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
